// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: FSM states, error codes
// and the default frame start marker.
package uart_cmd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_LEN    = 3'd2,
      ST_DATA   = 3'd3,
      ST_COMMIT = 3'd4,
      ST_REPORT = 3'd5
   } state_t;

   localparam logic [1:0] ERR_CHECKSUM = 2'd0;
   localparam logic [1:0] ERR_LEN      = 2'd1;
   localparam logic [1:0] ERR_ADDR     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream from the UART receiver in, register bank and commit/status
// signals out. master = byte source / observer, slave = the controller.
interface uart_cmd_ctrl_if #(
   parameter int NUM_REGS = 4
);
   localparam int ADDR_W = $clog2(NUM_REGS);

   logic                    rx_valid;
   logic [7:0]              rx_byte;
   logic [8*NUM_REGS-1:0]   reg_data;
   logic                    wr_strobe;
   logic [ADDR_W-1:0]       wr_addr;
   logic [7:0]              wr_data;
   logic                    frame_ok;
   logic                    frame_err;
   logic [1:0]              err_code;
   logic                    busy;

   modport master (
      output rx_valid, rx_byte,
      input  reg_data, wr_strobe, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
   );

   modport slave (
      input  rx_valid, rx_byte,
      output reg_data, wr_strobe, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
   );
endinterface

// File: rtl/uart_cmd_ctrl_frame_timer.sv
// Inter-byte gap counter: clears on every byte, expires one cycle-count short
// of LIMIT so the frame is dropped exactly LIMIT cycles after the last byte.
module uart_cmd_ctrl_frame_timer #(
   parameter int LIMIT = 25000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);
   localparam int CNT_W = $clog2(LIMIT) + 1;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (!reset_n || !enable || clear) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   // A byte arriving on the terminal cycle wins over the timeout.
   assign expired = enable && !clear && (count_reg == TERMINAL);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames SYNC/ADDR/LEN/DATA/CHK byte streams into checked write commands and
// commits the payload one byte per cycle into a small register bank.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int         CLOCK_HZ     = 12_000_000,
   parameter int         BAUD_RATE    = 9600,
   parameter int         TIMEOUT_BITS = 20,
   parameter int         NUM_REGS     = 4,
   parameter int         MAX_LEN      = 4,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic          clock,
   input  logic          reset_n,
   uart_cmd_ctrl_if.slave bus
);
   localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD_RATE;
   localparam int ADDR_W         = $clog2(NUM_REGS);
   localparam int LEN_W          = $clog2(MAX_LEN + 1);
   localparam int BUF_IW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [LEN_W-1:0]    len_reg, len_next;
   logic [LEN_W-1:0]    idx_reg, idx_next, idx_inc;
   logic [7:0]          chk_reg, chk_next;
   logic                frame_err_reg, err_fire;
   logic [1:0]          err_code_reg, err_code_next;
   logic                buf_we;
   logic [BUF_IW-1:0]   buf_idx;
   logic [7:0]          buf_mem [MAX_LEN];
   logic                timer_en, timer_expired;
   logic                commit_we;
   logic [ADDR_W-1:0]   commit_addr;
   logic [7:0]          commit_data;

   assign idx_inc  = idx_reg + LEN_W'(1);
   assign buf_idx  = BUF_IW'(idx_reg);
   assign timer_en = (state_reg == ST_ADDR) || (state_reg == ST_LEN) || (state_reg == ST_DATA);

   uart_cmd_ctrl_frame_timer #(
      .LIMIT (TIMEOUT_BITS * CYCLES_PER_BIT)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (timer_en),
      .clear   (bus.rx_valid),
      .expired (timer_expired)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         len_reg       <= '0;
         idx_reg       <= '0;
         chk_reg       <= '0;
         frame_err_reg <= 1'b0;
         err_code_reg  <= '0;
         for (int i = 0; i < MAX_LEN; i++) begin
            buf_mem[i] <= '0;
         end
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         len_reg       <= len_next;
         idx_reg       <= idx_next;
         chk_reg       <= chk_next;
         frame_err_reg <= err_fire;
         err_code_reg  <= err_code_next;
         if (buf_we) begin
            buf_mem[buf_idx] <= bus.rx_byte;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      len_next      = len_reg;
      idx_next      = idx_reg;
      chk_next      = chk_reg;
      err_fire      = 1'b0;
      err_code_next = err_code_reg;
      buf_we        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) begin
               state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (bus.rx_valid) begin
               if (int'(bus.rx_byte) >= NUM_REGS) begin
                  err_fire      = 1'b1;
                  err_code_next = ERR_ADDR;
                  state_next    = ST_IDLE;
               end else begin
                  addr_next  = ADDR_W'(bus.rx_byte);
                  chk_next   = bus.rx_byte;
                  state_next = ST_LEN;
               end
            end else if (timer_expired) begin
               err_fire      = 1'b1;
               err_code_next = ERR_TIMEOUT;
               state_next    = ST_IDLE;
            end
         end
         ST_LEN: begin
            if (bus.rx_valid) begin
               if (bus.rx_byte == 8'd0 || int'(bus.rx_byte) > MAX_LEN) begin
                  err_fire      = 1'b1;
                  err_code_next = ERR_LEN;
                  state_next    = ST_IDLE;
               end else begin
                  len_next   = LEN_W'(bus.rx_byte);
                  chk_next   = chk_reg ^ bus.rx_byte;
                  idx_next   = '0;
                  state_next = ST_DATA;
               end
            end else if (timer_expired) begin
               err_fire      = 1'b1;
               err_code_next = ERR_TIMEOUT;
               state_next    = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (bus.rx_valid) begin
               // Once the payload is full, the byte is the checksum.
               if (idx_reg == len_reg) begin
                  if (bus.rx_byte == chk_reg) begin
                     idx_next   = '0;
                     state_next = ST_COMMIT;
                  end else begin
                     err_fire      = 1'b1;
                     err_code_next = ERR_CHECKSUM;
                     state_next    = ST_IDLE;
                  end
               end else begin
                  buf_we   = 1'b1;
                  chk_next = chk_reg ^ bus.rx_byte;
                  idx_next = idx_inc;
               end
            end else if (timer_expired) begin
               err_fire      = 1'b1;
               err_code_next = ERR_TIMEOUT;
               state_next    = ST_IDLE;
            end
         end
         ST_COMMIT: begin
            idx_next = idx_inc;
            if (idx_inc == len_reg) begin
               state_next = ST_REPORT;
            end
         end
         ST_REPORT: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      commit_we     = (state_reg == ST_COMMIT);
      commit_addr   = '0;
      commit_data   = '0;
      if (commit_we) begin
         commit_addr = addr_reg + ADDR_W'(idx_reg);
         commit_data = buf_mem[buf_idx];
      end
      bus.wr_strobe = commit_we;
      bus.wr_addr   = commit_addr;
      bus.wr_data   = commit_data;
      bus.frame_ok  = (state_reg == ST_REPORT);
      bus.frame_err = frame_err_reg;
      bus.err_code  = err_code_reg;
      bus.busy      = (state_reg != ST_IDLE);
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
         logic [7:0] bank_reg;
         always_ff @(posedge clock) begin
            if (!reset_n) begin
               bank_reg <= '0;
            end else if (commit_we && commit_addr == ADDR_W'(gi)) begin
               bank_reg <= commit_data;
            end
         end
         assign bus.reg_data[8*gi +: 8] = bank_reg;
      end
   endgenerate

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected writes/reports/errors are queued
// as frames are driven and matched against DUT output events.
module tb_uart_cmd_ctrl;

   localparam int CLOCK_HZ  = 12_000_000;
   localparam int BAUD_RATE = 9600;
   localparam int TMO_BITS  = 20;
   localparam int NUM_REGS  = 4;
   localparam int MAX_LEN   = 4;
   localparam int TMO_CYC   = TMO_BITS * (CLOCK_HZ / BAUD_RATE);

   localparam int K_WR  = 0;
   localparam int K_OK  = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int kind;
      int addr;
      int data;
      int lat;
   } exp_t;

   logic clock;
   logic reset_n;
   int   cyc;
   int   byte_cyc;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];
   logic [7:0] exp_regs [NUM_REGS];

   uart_cmd_ctrl_if #(.NUM_REGS(NUM_REGS)) bus ();

   uart_cmd_ctrl #(
      .CLOCK_HZ     (CLOCK_HZ),
      .BAUD_RATE    (BAUD_RATE),
      .TIMEOUT_BITS (TMO_BITS),
      .NUM_REGS     (NUM_REGS),
      .MAX_LEN      (MAX_LEN),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
      end
   endtask

   task automatic push(input int kind, input int addr, input int data, input int lat);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.lat  = lat;
      sb.push_back(e);
      if (kind == K_WR) exp_regs[addr] = data[7:0];
   endtask

   // Expected commit of a good frame: writes at byte_cyc+k, frame_ok after them.
   task automatic push_frame(input int addr, input int len, input logic [7:0] d0, input logic [7:0] d1);
      logic [7:0] d [2];
      d[0] = d0;
      d[1] = d1;
      for (int k = 0; k < len; k++) push(K_WR, (addr + k) % NUM_REGS, int'(d[k]), k);
      push(K_OK, 0, 0, len);
   endtask

   task automatic pop_check(input int kind, input int addr, input int data);
      exp_t e;
      check("sb_nonempty", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("evt_kind", kind, e.kind);
         check("evt_lat", cyc - byte_cyc, e.lat);
         if (e.kind == kind && kind == K_WR) begin
            check("wr_addr", addr, e.addr);
            check("wr_data", data, e.data);
         end
         if (e.kind == kind && kind == K_ERR) check("err_code", data, e.data);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.wr_strobe) pop_check(K_WR, int'(bus.wr_addr), int'(bus.wr_data));
         if (bus.frame_ok)  pop_check(K_OK, 0, 0);
         if (bus.frame_err) pop_check(K_ERR, 0, int'(bus.err_code));
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      byte_cyc     = cyc + 1;
      @(negedge clock);
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Byte stream with a short inter-byte gap; the last byte leaves us at the
   // negedge right after its sampling edge.
   task automatic send6(input logic [7:0] b0, b1, b2, b3, b4, b5);
      send_byte(b0); gap(2);
      send_byte(b1); gap(2);
      send_byte(b2); gap(2);
      send_byte(b3); gap(2);
      send_byte(b4); gap(2);
      send_byte(b5);
   endtask

   task automatic wait_idle(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (bus.busy && n < TMO_CYC + 1000) begin
         @(negedge clock);
         n++;
      end
      check(tag, cyc - byte_cyc, exp_lat);
      gap(2);
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NUM_REGS; i++)
         check($sformatf("%s_reg%0d", tag, i), bus.reg_data[8*i +: 8], exp_regs[i]);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      byte_cyc     = 0;
      reset_n      = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
      gap(3);
      reset_n = 1'b1;
      gap(1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_wr_strobe", bus.wr_strobe, 1'b0);
      check("rst_frame_ok", bus.frame_ok, 1'b0);
      check("rst_frame_err", bus.frame_err, 1'b0);
      check("rst_err_code", bus.err_code, 2'd0);
      check_regs("rst");

      // 1: good frame, two writes
      push_frame(1, 2, 8'h11, 8'h22);
      send6(8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30);
      wait_idle("c1_busy", 3);
      check_regs("c1");

      // 2: checksum error
      push(K_ERR, 0, 0, 0);
      send6(8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31);
      wait_idle("c2_busy", 0);
      check_regs("c2");

      // 3: bad LEN (0 and >MAX_LEN), bad ADDR
      send_byte(8'hA5); gap(2);
      check("c3_busy_mid", bus.busy, 1'b1);
      send_byte(8'h00); gap(2);
      push(K_ERR, 0, 1, 0);
      send_byte(8'h00);
      wait_idle("c3a_busy", 0);
      send_byte(8'hA5); gap(2);
      send_byte(8'h00); gap(2);
      push(K_ERR, 0, 1, 0);
      send_byte(8'h05);
      wait_idle("c3b_busy", 0);
      check("c3_err_held", bus.err_code, 2'd1);
      send_byte(8'hA5); gap(2);
      push(K_ERR, 0, 2, 0);
      send_byte(8'h04);
      wait_idle("c3c_busy", 0);
      check("c3_err_held2", bus.err_code, 2'd2);

      // 4: address wrap 3 -> 0
      push_frame(3, 2, 8'hAA, 8'hBB);
      send6(8'hA5, 8'h03, 8'h02, 8'hAA, 8'hBB, 8'h10);
      wait_idle("c4_busy", 3);
      check_regs("c4");

      // 5: ignored bytes in IDLE, then timeout after ADDR
      send_byte(8'h00); gap(2);
      send_byte(8'hFF); gap(2);
      check("c5_idle_ignore", bus.busy, 1'b0);
      send_byte(8'hA5); gap(2);
      push(K_ERR, 0, 3, TMO_CYC);
      send_byte(8'h01);
      wait_idle("c5_tmo_busy", TMO_CYC);
      check_regs("c5");
      push_frame(1, 2, 8'h11, 8'h22);
      send6(8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30);
      wait_idle("c5b_busy", 3);
      check_regs("c5b");

      // 6: reset mid-frame, then a fresh frame
      send_byte(8'hA5); gap(2);
      send_byte(8'h01); gap(2);
      send_byte(8'h02); gap(2);
      send_byte(8'h11);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
      gap(1);
      check("c6_rst_busy", bus.busy, 1'b0);
      check_regs("c6_rst");
      push_frame(3, 2, 8'hAA, 8'hBB);
      send6(8'hA5, 8'h03, 8'h02, 8'hAA, 8'hBB, 8'h10);
      wait_idle("c6_busy", 3);
      check_regs("c6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
